// File: rtl/reg_writeback.sv
// Write-back stage: merges ALU and load results onto the single register-file write port,
// tracks registers with outstanding loads. Define WB_FORWARD_EN to forward the in-flight write to operands.
module reg_writeback #(
    parameter int WORD_SIZE = 18,
    parameter int REG_COUNT = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [2:0]           alu_addr,
    input  logic [WORD_SIZE-1:0] alu_data,
    input  logic                 load_issue,
    input  logic [2:0]           load_issue_addr,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [2:0]           mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic                 write_enable,
    output logic [2:0]           write_addr,
    output logic [WORD_SIZE-1:0] write_data,
    output logic [REG_COUNT-1:0] busy_mask,
    input  logic [2:0]           rd_addr0,
    input  logic [2:0]           rd_addr1,
    input  logic [WORD_SIZE-1:0] rf_data0,
    input  logic [WORD_SIZE-1:0] rf_data1,
    output logic [WORD_SIZE-1:0] op_data0,
    output logic [WORD_SIZE-1:0] op_data1,
    output logic                 wb_error
);

    logic [2:0]           fifo_addr_r [0:1];
    logic [WORD_SIZE-1:0] fifo_data_r [0:1];
    logic                 rd_ptr_r;
    logic                 wr_ptr_r;
    logic [1:0]           count_r;
    logic                 write_enable_r;
    logic [2:0]           write_addr_r;
    logic [WORD_SIZE-1:0] write_data_r;
    logic [REG_COUNT-1:0] busy_r;
    logic                 wb_error_r;

    logic                 xfer_s;
    logic                 nonempty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 wr_en_s;
    logic [2:0]           wr_addr_s;
    logic [WORD_SIZE-1:0] wr_data_s;
    logic                 load_write_s;
    logic [2:0]           load_addr_s;
    logic [REG_COUNT-1:0] set_s;
    logic [REG_COUNT-1:0] clear_s;
    logic [REG_COUNT-1:0] busy_next_s;
    logic                 error_s;
    logic [1:0]           count_next_s;

    // Readiness depends only on buffer occupancy so the load path never sees a combinational loop.
    assign mem_ready = (count_r < 2'd2);

    // Fixed-priority write-port arbitration: ALU, then buffered load, then bypassed load.
    always_comb begin
        xfer_s       = mem_valid && mem_ready;
        nonempty_s   = (count_r != 2'd0);
        push_s       = 1'b0;
        pop_s        = 1'b0;
        wr_en_s      = 1'b0;
        wr_addr_s    = write_addr_r;
        wr_data_s    = write_data_r;
        load_write_s = 1'b0;
        load_addr_s  = mem_addr;
        if (alu_valid) begin
            wr_en_s   = 1'b1;
            wr_addr_s = alu_addr;
            wr_data_s = alu_data;
            push_s    = xfer_s;
        end else if (nonempty_s) begin
            wr_en_s      = 1'b1;
            wr_addr_s    = fifo_addr_r[rd_ptr_r];
            wr_data_s    = fifo_data_r[rd_ptr_r];
            pop_s        = 1'b1;
            push_s       = xfer_s;
            load_write_s = 1'b1;
            load_addr_s  = fifo_addr_r[rd_ptr_r];
        end else if (xfer_s) begin
            wr_en_s      = 1'b1;
            wr_addr_s    = mem_addr;
            wr_data_s    = mem_data;
            load_write_s = 1'b1;
            load_addr_s  = mem_addr;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Scoreboard update; a set in the same cycle as a clear of the same bit wins.
    always_comb begin
        set_s   = {REG_COUNT{1'b0}};
        clear_s = {REG_COUNT{1'b0}};
        if (load_issue) begin
            set_s[load_issue_addr] = 1'b1;
        end else begin
            set_s = {REG_COUNT{1'b0}};
        end
        if (load_write_s) begin
            clear_s[load_addr_s] = 1'b1;
        end else begin
            clear_s = {REG_COUNT{1'b0}};
        end
        busy_next_s = (busy_r & ~clear_s) | set_s;
        error_s = (alu_valid && busy_r[alu_addr])
               || (load_issue && busy_r[load_issue_addr])
               || (load_write_s && !busy_r[load_addr_s]);
    end

    // Buffer occupancy tracking.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // Load buffer storage and pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_r       <= 1'b0;
            wr_ptr_r       <= 1'b0;
            count_r        <= 2'd0;
            fifo_addr_r[0] <= 3'd0;
            fifo_addr_r[1] <= 3'd0;
            fifo_data_r[0] <= {WORD_SIZE{1'b0}};
            fifo_data_r[1] <= {WORD_SIZE{1'b0}};
        end else begin
            count_r <= count_next_s;
            if (push_s) begin
                fifo_addr_r[wr_ptr_r] <= mem_addr;
                fifo_data_r[wr_ptr_r] <= mem_data;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
        end
    end

    // Registered write port, scoreboard and sticky error flag; address/data hold when idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_enable_r <= 1'b0;
            write_addr_r   <= 3'd0;
            write_data_r   <= {WORD_SIZE{1'b0}};
            busy_r         <= {REG_COUNT{1'b0}};
            wb_error_r     <= 1'b0;
        end else begin
            write_enable_r <= wr_en_s;
            write_addr_r   <= wr_addr_s;
            write_data_r   <= wr_data_s;
            busy_r         <= busy_next_s;
            wb_error_r     <= wb_error_r | error_s;
        end
    end

    assign write_enable = write_enable_r;
    assign write_addr   = write_addr_r;
    assign write_data   = write_data_r;
    assign busy_mask    = busy_r;
    assign wb_error     = wb_error_r;

`ifdef WB_FORWARD_EN
    // The regfile commits one edge after write_enable, so bypass the pending write.
    assign op_data0 = (write_enable_r && (write_addr_r == rd_addr0)) ? write_data_r : rf_data0;
    assign op_data1 = (write_enable_r && (write_addr_r == rd_addr1)) ? write_data_r : rf_data1;
`else
    logic unused_rd_s;
    assign unused_rd_s = ^{rd_addr0, rd_addr1};
    assign op_data0 = rf_data0;
    assign op_data1 = rf_data1;
`endif

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back stage of the 18-bit core: the single producer that drives the register file's only write port. Merges results from the ALU (never stalls) and the memory-load path (valid/ready) onto one registered write port. Keeps a busy scoreboard of registers with outstanding loads and, optionally, forwards the in-flight write to the two operand read ports.

## Interface
Parameters:
- WORD_SIZE, 18, data width
- REG_COUNT, 8, number of registers; addresses 3 bits; rx7 is sp and gets no special treatment

Ports:
- clock  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  3  ALU destination register
- alu_data  in  WORD_SIZE  ALU result
- load_issue  in  1  load issued this cycle; marks destination busy
- load_issue_addr  in  3  destination of issued load
- mem_valid  in  1  load data present
- mem_ready  out  1  block accepts load data
- mem_addr  in  3  load destination register
- mem_data  in  WORD_SIZE  load data
- write_enable  out  1  register file write strobe
- write_addr  out  3  register file write address
- write_data  out  WORD_SIZE  register file write data
- busy_mask  out  REG_COUNT  bit n set: register n awaits a load
- rd_addr0, rd_addr1  in  3  operand read addresses (same as regfile read ports)
- rf_data0, rf_data1  in  WORD_SIZE  raw regfile read data
- op_data0, op_data1  out  WORD_SIZE  operand data to execute stage
- wb_error  out  1  sticky protocol-violation flag

## Operation
- Load buffer: 2-entry FIFO of {addr, data}. mem_ready = (count < 2), a function of registered state only; a transfer occurs when mem_valid && mem_ready.
- Arbitration, evaluated each cycle; ALU has fixed priority:
  - alu_valid: write ALU result. A load transfer this cycle is pushed into the FIFO.
  - else FIFO non-empty: pop head and write it; a load transfer this cycle is pushed behind it (simultaneous push and pop keeps count).
  - else a load transfer this cycle bypasses the FIFO and is written directly.
  - else write_enable = 0; write_addr and write_data hold their previous values.
- Scoreboard: load_issue sets busy_mask[load_issue_addr]. A load write (FIFO pop or bypass) clears busy_mask[addr] on the same edge that asserts write_enable for it. If a set and a clear target the same bit in the same cycle, the set wins.
- Violations set wb_error, which stays set until reset:
  - alu_valid to a busy register
  - load_issue to a busy register
  - a load write whose register is not busy
- The write proceeds regardless of a violation.
- FIFO order is strict: loads retire in acceptance order.

## Timing
- Reset values: write_enable 0, write_addr 0, write_data 0, busy_mask 0, FIFO empty, mem_ready 1, wb_error 0. Reset mid-operation discards buffered loads and clears all busy bits.
- ALU result: write_enable is asserted 1 cycle after alu_valid.
- Load, bypass path: write_enable is asserted 1 cycle after the transfer.
- Load via FIFO: latency is at least 2 cycles; each cycle with alu_valid high adds 1.
- With alu_valid high continuously, the FIFO fills after two accepted loads and mem_ready drops on the following cycle. mem_ready returns high the cycle after the first pop.
- The regfile commits the write on the edge after write_enable. Operand reads in the write_enable cycle therefore see stale regfile data unless forwarding is enabled.

## Configuration
- Macro WB_FORWARD_EN.
- Defined: op_dataN = (write_enable && write_addr == rd_addrN) ? write_data : rf_dataN (combinational, both ports independent).
- Undefined: op_dataN = rf_dataN. Issue logic must then wait one extra cycle after busy_mask clears before reading the register.

## Test plan
- Reset, then ALU write r3 = 0x2AAAA: write_enable is 1 for one cycle with addr 3 and data 0x2AAAA; busy_mask stays 0; wb_error stays 0.
- Issue load r5, then mem_valid with r5 = 0x00123 while the ALU is idle: busy_mask = 0x20 until the bypass write, then clears on the same edge the write occurs.
- ALU valid for 4 consecutive cycles while loads r1 = 0x1 and r2 = 0x2 arrive:
  - loads are buffered and mem_ready drops while the FIFO is full
  - after the ALU goes idle, r1 then r2 are written on consecutive cycles
  - mem_ready returns to 1
- With WB_FORWARD_EN, rd_addr0 = 6 during an ALU write to r6 of 0x3FFFF while rf_data0 = 0: op_data0 = 0x3FFFF. Without the macro, op_data0 = 0.
- Load issued to r4, then an ALU write to r4: wb_error goes to 1 and stays 1 until reset. Assert reset while the FIFO is full: the FIFO empties, busy_mask = 0 and mem_ready = 1.
